// File: rtl/pos_cell_reader_pkg.sv
// pos_pkg: shared types and constants for the cell position reader.
// Holds FSM encoding, memory read latency and skid FIFO geometry.
package pos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    FIN
  } state_t;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_LW    = FIFO_PW + 1;

endpackage

// File: rtl/pos_cell_reader_if.sv
// pos_cell_reader_if: cell memory port plus position stream handshake.
// master = reader side, slave = memory/consumer side.
interface pos_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] cell_address;
  logic                  cell_rden;
  logic                  cell_wren;
  logic [DATA_WIDTH-1:0] cell_q;
  logic [DATA_WIDTH-1:0] pos_out;
  logic [ADDR_WIDTH-1:0] pid_out;
  logic                  pos_valid;
  logic                  pos_ready;
  logic                  pos_last;

  modport master (
    output cell_address,
    output cell_rden,
    output cell_wren,
    input  cell_q,
    output pos_out,
    output pid_out,
    output pos_valid,
    input  pos_ready,
    output pos_last
  );

  modport slave (
    input  cell_address,
    input  cell_rden,
    input  cell_wren,
    output cell_q,
    input  pos_out,
    input  pid_out,
    input  pos_valid,
    output pos_ready,
    input  pos_last
  );
endinterface

// File: rtl/pos_skid_fifo.sv
// pos_skid_fifo: 4-deep first-word fall-through FIFO for returned words.
// An empty FIFO passes the incoming word straight to its head.
module pos_skid_fifo
  import pos_pkg::*;
#(
  parameter int W = 104
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  input  logic               out_ready,
  output logic [FIFO_LW-1:0] level,
  output logic               empty_nxt
);

  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr;
  logic [FIFO_PW-1:0] rd_ptr;
  logic [FIFO_LW-1:0] level_nxt;
  logic               empty;
  logic               push;
  logic               pop;

  always_comb begin
    empty     = (level == '0);
    out_valid = empty ? in_valid : 1'b1;
    out_data  = '0;
    if (out_valid)
      out_data = empty ? in_data : mem[rd_ptr];
    pop       = !empty && out_ready;
    // bypassed word consumed in the same cycle never lands in storage
    push      = in_valid && !(empty && out_ready);
    level_nxt = level + FIFO_LW'(push) - FIFO_LW'(pop);
    empty_nxt = (level_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/pos_cell_reader.sv
// pos_cell_reader: reads one cell (count + positions) and streams pids.
// Optional macro POS_CELL_COUNT_CLAMP_EN clamps oversize counts.
module pos_cell_reader
  import pos_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
)(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic count_err,
  pos_cell_reader_if.master bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int FW = DW + AW;
  localparam logic [AW-1:0] CNT_MAX = AW'(PARTICLE_NUM - 1);
`ifdef POS_CELL_COUNT_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]      cnt;
  logic [AW-1:0]      nxt_pid;
  logic [AW-1:0]      addr_q;
  logic [1:0]         wcnt;
  logic [FIFO_LW-1:0] in_flight;
  logic [RD_LAT-1:0]  rv;
  logic [AW-1:0]      rpid [RD_LAT];

  logic               accept;
  logic               issue;
  logic               rd_cnt;
  logic               ret;
  logic               cnt_ld;
  logic               credit_ok;
  logic [FIFO_LW:0]   credit_sum;
  logic [AW-1:0]      cnt_raw;
  logic [AW-1:0]      cnt_new;
  logic               cnt_ovf;

  logic               f_valid;
  logic [FW-1:0]      f_data;
  logic [FIFO_LW-1:0] f_level;
  logic               f_empty_nxt;

  assign ret = rv[RD_LAT-1];

  always_comb begin
    cnt_raw    = bus.cell_q[AW-1:0];
    cnt_ovf    = CLAMP_EN && (cnt_raw > CNT_MAX);
    cnt_new    = cnt_ovf ? CNT_MAX : cnt_raw;
    credit_sum = {1'b0, in_flight} + {1'b0, f_level};
    credit_ok  = credit_sum < (FIFO_LW + 1)'(FIFO_DEPTH);
    accept     = start && (state == IDLE);
    cnt_ld     = (state == WAIT_CNT) && (wcnt == 2'(RD_LAT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = RD_CNT;
      RD_CNT:   state_nxt = WAIT_CNT;
      WAIT_CNT:
        if (cnt_ld)
          state_nxt = (cnt_new == '0) ? FIN : STREAM;
      STREAM:
        if (issue && nxt_pid == cnt)
          state_nxt = DRAIN;
      DRAIN:
        if (in_flight == FIFO_LW'(ret) && f_empty_nxt)
          state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_cnt           = (state == RD_CNT);
    issue            = (state == STREAM) && credit_ok;
    busy             = (state != IDLE);
    done             = (state == FIN);
    bus.cell_rden    = rd_cnt || issue;
    bus.cell_wren    = 1'b0;
    bus.cell_address = addr_q;
    if (rd_cnt)
      bus.cell_address = '0;
    else if (issue)
      bus.cell_address = nxt_pid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      nxt_pid   <= '0;
      addr_q    <= '0;
      wcnt      <= '0;
      in_flight <= '0;
      count_err <= 1'b0;
    end else begin
      in_flight <= in_flight + FIFO_LW'(issue) - FIFO_LW'(ret);
      if (accept) begin
        count_err <= 1'b0;
        nxt_pid   <= AW'(1);
      end
      if (rd_cnt) begin
        wcnt   <= '0;
        addr_q <= '0;
      end
      if (state == WAIT_CNT)
        wcnt <= wcnt + 1'b1;
      if (cnt_ld) begin
        cnt <= cnt_new;
        if (cnt_ovf)
          count_err <= 1'b1;
      end
      if (issue) begin
        addr_q  <= nxt_pid;
        nxt_pid <= nxt_pid + 1'b1;
      end
    end
  end

  // return pipeline tags each read with its pid until cell_q is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv <= '0;
      for (int i = 0; i < RD_LAT; i++)
        rpid[i] <= '0;
    end else begin
      rv[0]   <= issue;
      rpid[0] <= nxt_pid;
      for (int i = 1; i < RD_LAT; i++) begin
        rv[i]   <= rv[i-1];
        rpid[i] <= rpid[i-1];
      end
    end
  end

  pos_skid_fifo #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ret),
    .in_data   ({rpid[RD_LAT-1], bus.cell_q}),
    .out_valid (f_valid),
    .out_data  (f_data),
    .out_ready (bus.pos_ready),
    .level     (f_level),
    .empty_nxt (f_empty_nxt)
  );

  always_comb begin
    bus.pos_valid = f_valid;
    bus.pos_out   = f_data[DW-1:0];
    bus.pid_out   = f_data[FW-1:DW];
    bus.pos_last  = f_valid && (f_data[FW-1:DW] == cnt);
  end

endmodule

// File: doc/pos_cell_reader.md
POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 96, is the cell word width, {posz, posy, posx}, 32 bits each.
REQ-002 Parameter ADDR_WIDTH, default 8, is the cell memory address width.
REQ-003 Parameter PARTICLE_NUM, default 220, is the cell memory depth in words; address 0 holds the particle count.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse to begin reading one cell; ignored while busy=1.
REQ-007 cell_address  out  ADDR_WIDTH  address to the cell memory.
REQ-008 cell_rden  out  1  read enable to the cell memory.
REQ-009 cell_wren  out  1  write enable to the cell memory; constant 0.
REQ-010 cell_q  in  DATA_WIDTH  cell memory read data; valid exactly 2 cycles after the cycle in which cell_rden=1.
REQ-011 pos_out  out  DATA_WIDTH  particle position word.
REQ-012 pid_out  out  ADDR_WIDTH  particle index of pos_out, 1..count.
REQ-013 pos_valid  out  1  pos_out/pid_out valid.
REQ-014 pos_ready  in  1  downstream accept; a transfer occurs when pos_valid=1 and pos_ready=1.
REQ-015 pos_last  out  1  marks the final particle of the cell; qualified by pos_valid.
REQ-016 busy  out  1  cell read in progress.
REQ-017 done  out  1  one-cycle pulse when the cell is finished.
REQ-018 count_err  out  1  sticky flag: count word exceeded PARTICLE_NUM-1; cleared by start.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN and FIN.
REQ-020 IDLE->RD_CNT on start: drive address 0 with rden=1 for 1 cycle, then hold WAIT_CNT 2 cycles.
REQ-021 Count SHALL be cell_q[ADDR_WIDTH-1:0] captured at the end of WAIT_CNT; bits above are ignored.
REQ-022 A count of 0 SHALL go WAIT_CNT->FIN with no pos_valid asserted.
REQ-023 In STREAM, addresses 1..count SHALL be issued in order, one per cycle, when credit allows.
REQ-024 Credit rule: issue only if (reads in flight + FIFO occupancy) < 4; no word is ever dropped.
REQ-025 Returned words SHALL enter a 4-entry FIFO tagged with their pid; pos_out is the FIFO head.
REQ-026 With pos_ready held 1, the first pos_valid SHALL occur 6 cycles after start and throughput SHALL be 1 word/cycle.
REQ-027 pos_valid SHALL not drop, and pos_out/pid_out SHALL not change, while pos_valid=1 and pos_ready=0.
REQ-028 STREAM->DRAIN after address count is issued; DRAIN->FIN when the FIFO is empty and no reads are in flight.
REQ-029 FIN SHALL assert done for 1 cycle, then go to IDLE; busy=1 in every state except IDLE.
REQ-030 pos_last=1 when pid_out==count.
REQ-031 cell_rden SHALL be 0 whenever no read is issued; cell_address holds its last value otherwise.
REQ-032 A start that coincides with done SHALL be ignored.

Reset
REQ-033 rst_n low SHALL force IDLE, empty the FIFO and zero the in-flight counter, with outputs: pos_valid=0, pos_last=0, busy=0, done=0, count_err=0, cell_rden=0, cell_wren=0, cell_address=0, pos_out=0, pid_out=0.
REQ-034 Reset mid-stream SHALL discard every outstanding read; cell_q returning after release is ignored.

Configuration
REQ-035 With POS_CELL_COUNT_CLAMP_EN defined, a count > PARTICLE_NUM-1 SHALL be clamped to PARTICLE_NUM-1 and count_err set.
REQ-036 Without POS_CELL_COUNT_CLAMP_EN, the count is used raw and count_err is tied 0.

Structure
REQ-037 The shared package (pos_pkg) SHALL hold the FSM state encoding, the read latency (2) and the FIFO depth (4).
REQ-038 One sub-module, pos_skid_fifo (4-deep, DATA_WIDTH+ADDR_WIDTH wide, first-word fall-through), SHALL hold returned words.

Verification
REQ-039 Count=3, pos_ready=1: pids 1,2,3 on 3 consecutive cycles from 6 cycles after start, pos_last with pid 3, done 1 cycle after the last transfer.
REQ-040 Count=0: no pos_valid; done exactly 4 cycles after start.
REQ-041 Count=10, pos_ready toggling 1/0: all 10 words in order with none lost or duplicated; pos_out stable while stalled.
REQ-042 Count=8, pos_ready=0 for 20 cycles: at most 4 reads issued; the remainder resume once ready returns.
REQ-043 Count=250 (PARTICLE_NUM=220): with the macro, 219 words and count_err=1; without it, 250 words and count_err=0.
REQ-044 rst_n pulsed low at pid 4 of 10: outputs reach reset values immediately; a new start streams cleanly from pid 1.
